// File: rtl/mobius_pkg.sv
// Shared definitions for the Mobius transform sequencer: controller states
// and the butterfly span helper used by the stage datapath.
package mobius_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Distance between the two bits paired by stage s of an n-bit transform.
    function automatic int mobius_half(input int n, input int s);
        return n >> (s + 1);
    endfunction

endpackage

// File: rtl/mobius_stage_sel.sv
// One runtime-selectable butterfly stage of the binary Mobius transform.
// The controller reuses this single instance on every RUN cycle, stepping
// the stage index through 0..LOG2_N-1.
module mobius_stage_sel
    import mobius_pkg::*;
#(
    parameter int N      = 256,
    parameter int LOG2_N = 8
) (
    input  logic [0:N-1]        vec_in,
    input  logic [LOG2_N-1:0]   stage,
    output logic [0:N-1]        vec_out
);

    // Each output bit is its own input bit, optionally XORed with the partner
    // bit half positions to its left. Whether a partner exists depends only
    // on the bit position and the stage, so the candidates are fixed wiring
    // and the runtime stage just selects among them.
    for (genvar i = 0; i < N; i++) begin : g_bit
        logic [N-1:0] term;

        // Stage indices past the last stage never occur; tie those
        // candidates off so the select has a full power-of-two range.
        assign term[N-1:LOG2_N] = '0;

        for (genvar s = 0; s < LOG2_N; s++) begin : g_stage
            if ((i & mobius_half(N, s)) != 0) begin : g_upper
                assign term[s] = vec_in[i - mobius_half(N, s)];
            end else begin : g_lower
                assign term[s] = 1'b0;
            end
        end

        assign vec_out[i] = vec_in[i] ^ term[stage];
    end

endmodule

// File: rtl/mobius_seq_ctrl.sv
// Sequential Mobius transform engine: accepts an N-bit vector, applies the
// LOG2_N butterfly stages one per clock through a shared stage datapath,
// then presents the result with a valid/ready handshake.
module mobius_seq_ctrl
    import mobius_pkg::*;
#(
    parameter int N      = 256,
    parameter int LOG2_N = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [0:N-1]        in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [0:N-1]        out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic [LOG2_N-1:0]   stage_idx
);

    localparam logic [LOG2_N-1:0] LAST_STAGE = LOG2_N'(LOG2_N - 1);
    localparam logic [LOG2_N-1:0] STAGE_ONE  = LOG2_N'(1);

    state_t              state;
    logic [0:N-1]        work;
    logic [0:N-1]        stage_out;

    mobius_stage_sel #(
        .N      (N),
        .LOG2_N (LOG2_N)
    ) u_stage (
        .vec_in  (work),
        .stage   (stage_idx),
        .vec_out (stage_out)
    );

    // A new vector can enter when idle, or when the finished result is
    // leaving on the same edge so the pipeline never bubbles.
    always_comb begin
        in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    end

    assign out_valid = (state == DONE);
    assign busy      = (state == RUN);
    assign out_data  = work;

    // Controller: load on input transfer, one stage per RUN edge, hold the
    // result in DONE until the consumer takes it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            stage_idx <= '0;
            work      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        work      <= in_data;
                        stage_idx <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    work <= stage_out;
                    if (stage_idx == LAST_STAGE) begin
                        stage_idx <= '0;
                        state     <= DONE;
                    end else begin
                        stage_idx <= stage_idx + STAGE_ONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            work      <= in_data;
                            stage_idx <= '0;
                            state     <= RUN;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    stage_idx <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mobius_seq_ctrl.sv
// Directed testbench for mobius_seq_ctrl with N=8: reset state, latency,
// hand-computed vectors, involution against a reference model, output
// backpressure, back-to-back streaming and mid-operation reset.
module tb_mobius_seq_ctrl;

    localparam int N      = 8;
    localparam int LOG2_N = 3;

    logic              clk;
    logic              rst_n;
    logic [0:N-1]      in_data;
    logic              in_valid;
    logic              in_ready;
    logic [0:N-1]      out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic [LOG2_N-1:0] stage_idx;

    int testCount;
    int failCount;

    mobius_seq_ctrl #(
        .N      (N),
        .LOG2_N (LOG2_N)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .stage_idx (stage_idx)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: out[i] is the XOR of x[j] over every index j whose set bits
    // are a subset of the set bits of i.
    function automatic logic [0:N-1] mobiusRef(input logic [0:N-1] x);
        logic [0:N-1] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if ((j & i) == j) r[3'(i)] = r[3'(i)] ^ x[3'(j)];
            end
        end
        return r;
    endfunction

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push one vector through a full handshake and return the result.
    task automatic applyStimulus(input logic [0:N-1] x, output logic [0:N-1] y);
        int waitCycles;
        waitCycles = 0;
        while (!in_ready && waitCycles < 20) begin
            tick();
            waitCycles++;
        end
        if (!in_ready) checkOutput("in_ready_timeout", 32'd0, 32'd1);
        in_valid = 1'b1;
        in_data  = x;
        tick();
        in_valid = 1'b0;
        waitCycles = 0;
        while (!out_valid && waitCycles < 20) begin
            tick();
            waitCycles++;
        end
        if (!out_valid) checkOutput("out_valid_timeout", 32'd0, 32'd1);
        y = out_data;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    logic [0:N-1] held;
    logic [0:N-1] res1;
    logic [0:N-1] res2;
    logic [0:N-1] xr;
    logic [0:N-1] streamVec [4];

    initial begin
        testCount = 0;
        failCount = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset state
        tick();
        tick();
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_busy",      32'(busy),      32'd0);
        checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
        checkOutput("rst_out_data",  32'(out_data),  32'h00);
        checkOutput("rst_stage_idx", 32'(stage_idx), 32'd0);

        // Latency: first edge with rst_n high accepts the vector (edge T)
        rst_n    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'b1000_0000;
        tick();
        checkOutput("lat_T_busy",     32'(busy),      32'd1);
        checkOutput("lat_T_stage",    32'(stage_idx), 32'd0);
        checkOutput("lat_T_in_ready", 32'(in_ready),  32'd0);
        checkOutput("lat_T_valid",    32'(out_valid), 32'd0);
        // Input offered during RUN must be ignored
        in_data  = 8'b0101_0101;
        tick();
        checkOutput("lat_T1_busy",  32'(busy),      32'd1);
        checkOutput("lat_T1_stage", 32'(stage_idx), 32'd1);
        checkOutput("lat_T1_valid", 32'(out_valid), 32'd0);
        tick();
        checkOutput("lat_T2_busy",  32'(busy),      32'd1);
        checkOutput("lat_T2_stage", 32'(stage_idx), 32'd2);
        checkOutput("lat_T2_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        tick();
        checkOutput("lat_T3_valid", 32'(out_valid), 32'd1);
        checkOutput("lat_T3_busy",  32'(busy),      32'd0);
        checkOutput("lat_T3_data",  32'(out_data),  32'hFF);
        checkOutput("lat_T3_stage", 32'(stage_idx), 32'd0);

        // Backpressure: result held for 5 cycles with out_ready low
        held = out_data;
        for (int c = 0; c < 5; c++) begin
            tick();
            checkOutput("bp_valid",    32'(out_valid), 32'd1);
            checkOutput("bp_data",     32'(out_data),  32'(held));
            checkOutput("bp_in_ready", 32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("bp_after_valid",    32'(out_valid), 32'd0);
        checkOutput("bp_after_in_ready", 32'(in_ready),  32'd1);
        tick();
        checkOutput("bp_single_xfer", 32'(out_valid), 32'd0);

        // Hand-computed vectors
        applyStimulus(8'b1111_1111, res1);
        checkOutput("vec_ff", 32'(res1), 32'h80);
        applyStimulus(8'b0000_0001, res1);
        checkOutput("vec_01", 32'(res1), 32'h01);
        applyStimulus(8'b1100_0000, res1);
        checkOutput("vec_c0", 32'(res1), 32'hAA);

        // Involution over random vectors
        for (int k = 0; k < 1000; k++) begin
            xr = 8'($urandom);
            applyStimulus(xr, res1);
            checkOutput("inv_model", 32'(res1), 32'(mobiusRef(xr)));
            applyStimulus(res1, res2);
            checkOutput("inv_back", 32'(res2), 32'(xr));
        end

        // Back-to-back streaming: one result every 4 cycles
        streamVec[0] = 8'b1000_0000;
        streamVec[1] = 8'b1111_1111;
        streamVec[2] = 8'b0011_0101;
        streamVec[3] = 8'b1110_0010;
        in_valid  = 1'b1;
        in_data   = streamVec[0];
        out_ready = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            repeat (2) tick();
            checkOutput("b2b_not_yet", 32'(out_valid), 32'd0);
            tick();
            checkOutput("b2b_valid",    32'(out_valid), 32'd1);
            checkOutput("b2b_data",     32'(out_data),  32'(mobiusRef(streamVec[k])));
            checkOutput("b2b_in_ready", 32'(in_ready),  32'd1);
            if (k < 3) in_data = streamVec[k + 1];
            else       in_valid = 1'b0;
            tick();
            if (k < 3) begin
                checkOutput("b2b_reload_busy",  32'(busy),      32'd1);
                checkOutput("b2b_reload_stage", 32'(stage_idx), 32'd0);
            end
        end
        out_ready = 1'b0;
        checkOutput("b2b_end_busy",     32'(busy),     32'd0);
        checkOutput("b2b_end_in_ready", 32'(in_ready), 32'd1);

        // Mid-operation reset while stage_idx is 1
        in_valid = 1'b1;
        in_data  = 8'b0110_1001;
        tick();
        in_valid = 1'b0;
        tick();
        checkOutput("mr_stage", 32'(stage_idx), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("mr_busy",     32'(busy),      32'd0);
        checkOutput("mr_valid",    32'(out_valid), 32'd0);
        checkOutput("mr_in_ready", 32'(in_ready),  32'd1);
        checkOutput("mr_data",     32'(out_data),  32'h00);
        for (int c = 0; c < 6; c++) begin
            tick();
            checkOutput("mr_no_valid", 32'(out_valid), 32'd0);
        end
        applyStimulus(8'b1000_0000, res1);
        checkOutput("mr_next_vec", 32'(res1), 32'hFF);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
